hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline.
- Compares D-stage source registers against the destinations held in E/M/W pipeline registers, using Tuse/Tnew timing.
- Drives the stall/flush controls for PC, D_REG and E_REG, and the D-stage forwarding selects.
- Owns the multiply/divide busy scheduler: counts down unit occupancy and blocks md-class instructions in D until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu starts in E.
- DIV_CYCLES, 10, busy cycles after a div/divu starts in E.
- CNT_W, 4, md busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).
- PERF_W, 32, stall performance counter width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- D_rs  in  5  rs field of the instruction in D.
- D_rt  in  5  rt field of the instruction in D.
- D_use_rs  in  1  D instruction reads rs.
- D_use_rt  in  1  D instruction reads rt.
- D_rs_tuse  in  2  cycles until D needs rs (0..2).
- D_rt_tuse  in  2  cycles until D needs rt (0..2).
- D_is_md  in  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- E_writeReg_NUM  in  5  destination register of E; 0 means none.
- E_tnew  in  2  cycles until the E result is ready.
- M_writeReg_NUM  in  5  destination register of M.
- M_tnew  in  2  cycles until the M result is ready.
- W_writeReg_NUM  in  5  destination register of W.
- E_md_start  in  1  a mult/div is in E this cycle (single-cycle pulse).
- E_md_is_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu.
- stall  out  1  freeze PC and D_REG, and flush E_REG (insert bubble).
- md_busy  out  1  md unit is occupied.
- D_rs_fwd  out  2  rs source select: 0 regfile, 1 E, 2 M, 3 W.
- D_rt_fwd  out  2  rt source select, same encoding.
- stall_cnt  out  PERF_W  number of cycles in which stall was asserted.

Behaviour:
- Register-match rule: a match for register r requires r != 0 and r equal to the stage's writeReg_NUM.
- Data stall (rs): D_use_rs && match(D_rs, E) && E_tnew > D_rs_tuse; OR D_use_rs && match(D_rs, M) && M_tnew > D_rs_tuse.
- Data stall (rt): same rule using D_use_rt, D_rt and D_rt_tuse.
- MD stall: D_is_md && md_busy.
- stall = data stall OR md stall. It is combinational from the inputs and registered state, with zero latency.
- Forward select (rs and rt independently), priority E > M > W:
  - 1 if match in E and E_tnew == 0;
  - else 2 if match in M and M_tnew == 0;
  - else 3 if match in W;
  - else 0.
  - The select is computed even when the corresponding use flag is 0.
- MD scheduler state is md_cnt[CNT_W-1:0] plus state IDLE/BUSY, derived as md_cnt != 0.
  - IDLE -> BUSY on E_md_start: md_cnt <= E_md_is_div ? DIV_CYCLES : MULT_CYCLES.
  - BUSY: md_cnt decrements by 1 each cycle; BUSY -> IDLE when md_cnt reaches 0.
  - md_busy = E_md_start || (md_cnt != 0). It is asserted in the start cycle itself, so an md instruction in D directly behind the mult is blocked.
  - Total md_busy high time = N+1 cycles, where N = MULT_CYCLES or DIV_CYCLES.
- E_md_start while md_cnt != 0 cannot occur by construction, since stall prevents it. If it does occur, the counter reloads; this is not an error.
- stall_cnt increments by 1 on every posedge where stall == 1, and wraps silently at 2^PERF_W.
- Reset (synchronous, highest priority, also mid-count): md_cnt=0 and stall_cnt=0. Resulting outputs: md_busy=0 unless E_md_start, stall as combinationally implied, fwd selects combinational.
- Simultaneous events:
  - The md stall and data stall OR together.
  - A counter reaching 0 in the same cycle as a new E_md_start loads the new value.

Decomposition:
- Shared package holds:
  - forwarding select constants FWD_RF/FWD_E/FWD_M/FWD_W = 0..3;
  - Tuse/Tnew width constant (2);
  - MULT_CYCLES/DIV_CYCLES defaults.
- One sub-module, md_sched: the md_cnt counter and the md_busy output. It is instantiated once.
- Stall and forwarding compare logic stays at the top level and is instantiated twice, once for rs and once for rt, as a function or generate block.

Test Plan:
- Load-use: E_writeReg=5, E_tnew=2, D_rs=5, use_rs=1, rs_tuse=1 -> stall=1; the next cycle with E_tnew=0 in M-role gives stall=0 and D_rs_fwd=2.
- $0 hazard: all writeReg=0, D_rs=0 with tuse=0 -> stall=0 and D_rs_fwd=0 for every Tnew value.
- Priority: E, M and W all write reg 8, with E_tnew=0 and M_tnew=0, D_rt=8 -> D_rt_fwd=1. Then set E_writeReg=0 -> D_rt_fwd=2. Then set M_writeReg=0 -> D_rt_fwd=3.
- Mult busy: E_md_start=1, is_div=0, with D_is_md=1 held -> stall=1 for exactly 6 cycles, then 0. md_busy shows the same profile.
- Div plus reset: E_md_start with is_div=1, reset pulsed after 4 cycles -> md_busy=0 in the cycle after reset, and stall_cnt=0.
- Perf counter: 7 stall cycles -> stall_cnt=7. Preload to all-ones via forced stall and add 1 more stall -> wraps to 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned T_W              = 2;
    localparam int unsigned MULT_CYCLES_DEF  = 5;
    localparam int unsigned DIV_CYCLES_DEF   = 10;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic     stall;
        fwd_sel_e fwd;
    } src_hazard_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the pipeline, slave the controller.
interface hazard_ctrl_if #(
    parameter int unsigned PERF_W = 32
);
    import hazard_ctrl_pkg::*;

    logic [4:0]     D_rs;
    logic [4:0]     D_rt;
    logic           D_use_rs;
    logic           D_use_rt;
    logic [T_W-1:0] D_rs_tuse;
    logic [T_W-1:0] D_rt_tuse;
    logic           D_is_md;
    logic [4:0]     E_writeReg_NUM;
    logic [T_W-1:0] E_tnew;
    logic [4:0]     M_writeReg_NUM;
    logic [T_W-1:0] M_tnew;
    logic [4:0]     W_writeReg_NUM;
    logic           E_md_start;
    logic           E_md_is_div;

    logic              stall;
    logic              md_busy;
    logic [1:0]        D_rs_fwd;
    logic [1:0]        D_rt_fwd;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_use_rs, D_use_rt, D_rs_tuse, D_rt_tuse, D_is_md,
               E_writeReg_NUM, E_tnew, M_writeReg_NUM, M_tnew, W_writeReg_NUM,
               E_md_start, E_md_is_div,
        input  stall, md_busy, D_rs_fwd, D_rt_fwd, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_use_rs, D_use_rt, D_rs_tuse, D_rt_tuse, D_is_md,
               E_writeReg_NUM, E_tnew, M_writeReg_NUM, M_tnew, W_writeReg_NUM,
               E_md_start, E_md_is_div,
        output stall, md_busy, D_rs_fwd, D_rt_fwd, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_md_sched.sv
// Multiply/divide occupancy scheduler: busy from the start cycle until the countdown expires.
module md_sched
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_md_cnt_nxt;
    md_state_e        w_state;

    always_ff @(posedge clk) begin
        if (reset) r_md_cnt <= '0;
        else       r_md_cnt <= w_md_cnt_nxt;
    end

    // A start always reloads, including the cycle the old count would hit zero.
    always_comb begin
        w_md_cnt_nxt = r_md_cnt;
        w_state      = (r_md_cnt != '0) ? MD_BUSY : MD_IDLE;
        if (i_start)
            w_md_cnt_nxt = i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (w_state == MD_BUSY)
            w_md_cnt_nxt = r_md_cnt - CNT_W'(1);
        o_busy = i_start | (w_state == MD_BUSY);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: Tuse/Tnew stall detection, D-stage forwarding selects, md blocking.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned PERF_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    function automatic src_hazard_t resolve_src(
        input logic [4:0]     r,
        input logic           use_r,
        input logic [T_W-1:0] tuse,
        input logic [4:0]     e_wr,
        input logic [T_W-1:0] e_tnew,
        input logic [4:0]     m_wr,
        input logic [T_W-1:0] m_tnew,
        input logic [4:0]     w_wr
    );
        src_hazard_t res;
        logic        e_hit;
        logic        m_hit;
        logic        w_hit;
        e_hit     = (r != '0) && (r == e_wr);
        m_hit     = (r != '0) && (r == m_wr);
        w_hit     = (r != '0) && (r == w_wr);
        res.stall = use_r && ((e_hit && (e_tnew > tuse)) || (m_hit && (m_tnew > tuse)));
        res.fwd   = FWD_RF;
        // A not-yet-ready hit in E or M falls through to the next older stage.
        if (e_hit && (e_tnew == '0))      res.fwd = FWD_E;
        else if (m_hit && (m_tnew == '0)) res.fwd = FWD_M;
        else if (w_hit)                   res.fwd = FWD_W;
        return res;
    endfunction

    src_hazard_t       w_rs;
    src_hazard_t       w_rt;
    logic              w_md_busy;
    logic              w_stall;
    logic [PERF_W-1:0] r_stall_cnt;

    md_sched #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_sched (
        .clk      (clk),
        .reset    (reset),
        .i_start  (bus.E_md_start),
        .i_is_div (bus.E_md_is_div),
        .o_busy   (w_md_busy)
    );

    always_comb begin
        w_rs = resolve_src(bus.D_rs, bus.D_use_rs, bus.D_rs_tuse,
                           bus.E_writeReg_NUM, bus.E_tnew,
                           bus.M_writeReg_NUM, bus.M_tnew, bus.W_writeReg_NUM);
        w_rt = resolve_src(bus.D_rt, bus.D_use_rt, bus.D_rt_tuse,
                           bus.E_writeReg_NUM, bus.E_tnew,
                           bus.M_writeReg_NUM, bus.M_tnew, bus.W_writeReg_NUM);
        w_stall = w_rs.stall | w_rt.stall | (bus.D_is_md & w_md_busy);

        bus.stall     = w_stall;
        bus.md_busy   = w_md_busy;
        bus.D_rs_fwd  = w_rs.fwd;
        bus.D_rt_fwd  = w_rt.fwd;
        bus.stall_cnt = r_stall_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset)        r_stall_cnt <= '0;
        else if (w_stall) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; perf counter narrowed to 4 bits to reach the wrap.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned PW = 4;

    logic clk = 1'b0;
    logic reset;

    hazard_ctrl_if #(.PERF_W(PW)) hif ();

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4),
        .PERF_W      (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          stall;
        logic          busy;
        logic [1:0]    rsf;
        logic [1:0]    rtf;
        logic [PW-1:0] cnt;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            tests = 0;
    int            fails = 0;
    logic [PW-1:0] m_cnt;

    task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk(mon_e.name, "stall",     8'(hif.stall),     8'(mon_e.stall));
            chk(mon_e.name, "md_busy",   8'(hif.md_busy),   8'(mon_e.busy));
            chk(mon_e.name, "D_rs_fwd",  8'(hif.D_rs_fwd),  8'(mon_e.rsf));
            chk(mon_e.name, "D_rt_fwd",  8'(hif.D_rt_fwd),  8'(mon_e.rtf));
            chk(mon_e.name, "stall_cnt", 8'(hif.stall_cnt), 8'(mon_e.cnt));
        end
    end

    // Push the expected response for the current cycle, then advance; m_cnt tracks expected stalls.
    task automatic step(input string nm, input logic s, input logic b, input logic [1:0] rsf, input logic [1:0] rtf);
        exp_t e;
        e.name  = nm;
        e.stall = s;
        e.busy  = b;
        e.rsf   = rsf;
        e.rtf   = rtf;
        e.cnt   = m_cnt;
        q.push_back(e);
        @(posedge clk);
        if (reset)  m_cnt = '0;
        else if (s) m_cnt = m_cnt + PW'(1);
        #1;
    endtask

    task automatic idle_inputs();
        hif.D_rs = '0; hif.D_rt = '0; hif.D_use_rs = 1'b0; hif.D_use_rt = 1'b0;
        hif.D_rs_tuse = '0; hif.D_rt_tuse = '0; hif.D_is_md = 1'b0;
        hif.E_writeReg_NUM = '0; hif.E_tnew = '0;
        hif.M_writeReg_NUM = '0; hif.M_tnew = '0;
        hif.W_writeReg_NUM = '0;
        hif.E_md_start = 1'b0; hif.E_md_is_div = 1'b0;
    endtask

    task automatic forced_stall_inputs();
        idle_inputs();
        hif.E_writeReg_NUM = 5'd5; hif.E_tnew = 2'd2;
        hif.D_rs = 5'd5; hif.D_use_rs = 1'b1; hif.D_rs_tuse = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_cnt = '0;
        @(posedge clk); #1;
        step("reset", 1'b0, 1'b0, FWD_RF, FWD_RF);
        reset = 1'b0;

        // load-use and Tnew/Tuse boundaries
        hif.E_writeReg_NUM = 5'd5; hif.E_tnew = 2'd2;
        hif.D_rs = 5'd5; hif.D_use_rs = 1'b1; hif.D_rs_tuse = 2'd1;
        step("lu_stall", 1'b1, 1'b0, FWD_RF, FWD_RF);
        hif.E_writeReg_NUM = '0; hif.E_tnew = '0;
        hif.M_writeReg_NUM = 5'd5; hif.M_tnew = 2'd0;
        step("lu_fwdM", 1'b0, 1'b0, FWD_M, FWD_RF);
        hif.M_tnew = 2'd1; hif.D_rs_tuse = 2'd0;
        step("m_tnew_gt", 1'b1, 1'b0, FWD_RF, FWD_RF);
        hif.D_rs_tuse = 2'd1;
        step("m_tnew_eq", 1'b0, 1'b0, FWD_RF, FWD_RF);
        idle_inputs();
        hif.E_writeReg_NUM = 5'd5; hif.E_tnew = 2'd1; hif.W_writeReg_NUM = 5'd5;
        hif.D_rs = 5'd5; hif.D_use_rs = 1'b1; hif.D_rs_tuse = 2'd1;
        step("e_tnew_eq", 1'b0, 1'b0, FWD_W, FWD_RF);
        hif.D_use_rs = 1'b0; hif.E_tnew = 2'd2; hif.D_rs_tuse = 2'd0;
        step("no_use", 1'b0, 1'b0, FWD_W, FWD_RF);

        // register $0 never matches
        idle_inputs();
        hif.D_use_rs = 1'b1; hif.D_use_rt = 1'b1;
        for (int t = 0; t < 4; t++) begin
            hif.E_tnew = 2'(t); hif.M_tnew = 2'(t);
            step("zero_reg", 1'b0, 1'b0, FWD_RF, FWD_RF);
        end

        // forwarding priority E > M > W
        idle_inputs();
        hif.D_rt = 5'd8; hif.D_use_rt = 1'b1;
        hif.E_writeReg_NUM = 5'd8; hif.M_writeReg_NUM = 5'd8; hif.W_writeReg_NUM = 5'd8;
        step("pri_E", 1'b0, 1'b0, FWD_RF, FWD_E);
        hif.E_writeReg_NUM = '0;
        step("pri_M", 1'b0, 1'b0, FWD_RF, FWD_M);
        hif.M_writeReg_NUM = '0;
        step("pri_W", 1'b0, 1'b0, FWD_RF, FWD_W);
        hif.W_writeReg_NUM = '0;
        step("pri_none", 1'b0, 1'b0, FWD_RF, FWD_RF);
        hif.D_use_rt = 1'b0; hif.E_writeReg_NUM = 5'd8; hif.E_tnew = 2'd2;
        hif.M_writeReg_NUM = 5'd8; hif.M_tnew = 2'd0;
        step("rt_nouse", 1'b0, 1'b0, FWD_RF, FWD_M);
        idle_inputs();
        hif.D_rs = 5'd3; hif.D_use_rs = 1'b1; hif.E_writeReg_NUM = 5'd3; hif.E_tnew = 2'd1;
        hif.D_rt = 5'd8; hif.W_writeReg_NUM = 5'd8;
        step("indep", 1'b1, 1'b0, FWD_RF, FWD_W);

        // mult occupancy blocks an md instruction for 6 cycles
        idle_inputs();
        hif.D_is_md = 1'b1; hif.E_md_start = 1'b1;
        step("mul_start", 1'b1, 1'b1, FWD_RF, FWD_RF);
        hif.E_md_start = 1'b0;
        for (int i = 0; i < 5; i++) step("mul_busy", 1'b1, 1'b1, FWD_RF, FWD_RF);
        step("mul_done", 1'b0, 1'b0, FWD_RF, FWD_RF);

        // restart in the cycle the count reaches zero
        hif.D_is_md = 1'b0; hif.E_md_start = 1'b1;
        step("b2b_start", 1'b0, 1'b1, FWD_RF, FWD_RF);
        hif.E_md_start = 1'b0;
        for (int i = 0; i < 4; i++) step("b2b_busy", 1'b0, 1'b1, FWD_RF, FWD_RF);
        hif.E_md_start = 1'b1;
        step("b2b_reload", 1'b0, 1'b1, FWD_RF, FWD_RF);
        hif.E_md_start = 1'b0;
        for (int i = 0; i < 5; i++) step("b2b_busy2", 1'b0, 1'b1, FWD_RF, FWD_RF);
        step("b2b_done", 1'b0, 1'b0, FWD_RF, FWD_RF);

        // div interrupted by reset
        hif.D_is_md = 1'b1; hif.E_md_start = 1'b1; hif.E_md_is_div = 1'b1;
        step("div_start", 1'b1, 1'b1, FWD_RF, FWD_RF);
        hif.E_md_start = 1'b0;
        for (int i = 0; i < 3; i++) step("div_busy", 1'b1, 1'b1, FWD_RF, FWD_RF);
        reset = 1'b1;
        step("div_rst", 1'b1, 1'b1, FWD_RF, FWD_RF);
        reset = 1'b0;
        step("div_after_rst", 1'b0, 1'b0, FWD_RF, FWD_RF);
        hif.D_is_md = 1'b0; reset = 1'b1; hif.E_md_start = 1'b1;
        step("rst_start", 1'b0, 1'b1, FWD_RF, FWD_RF);
        hif.E_md_start = 1'b0;
        step("rst_noload", 1'b0, 1'b0, FWD_RF, FWD_RF);
        reset = 1'b0;
        step("rst_noload2", 1'b0, 1'b0, FWD_RF, FWD_RF);

        // perf counter: 7 stalls, then wrap at 2^PW
        idle_inputs(); reset = 1'b1;
        step("perf_rst", 1'b0, 1'b0, FWD_RF, FWD_RF);
        reset = 1'b0;
        forced_stall_inputs();
        for (int i = 0; i < 7; i++) step("perf_stall", 1'b1, 1'b0, FWD_RF, FWD_RF);
        idle_inputs();
        step("perf_7", 1'b0, 1'b0, FWD_RF, FWD_RF);
        forced_stall_inputs();
        for (int i = 0; i < 8; i++) step("perf_fill", 1'b1, 1'b0, FWD_RF, FWD_RF);
        idle_inputs();
        step("perf_ones", 1'b0, 1'b0, FWD_RF, FWD_RF);
        forced_stall_inputs();
        step("perf_last", 1'b1, 1'b0, FWD_RF, FWD_RF);
        idle_inputs();
        step("perf_wrap", 1'b0, 1'b0, FWD_RF, FWD_RF);

        @(negedge clk); #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
